vc_input_buffer: RTL and testbench
==================================

Name: vc_input_buffer

Overview:
- One virtual-channel input buffer of a hypercube router input port; four instances per port feed the per-port VC multiplexer (valid/vch/data/port/req per VC).
- Stores incoming flits in a FIFO and computes the e-cube output port from the head flit.
- Raises a crossbar request for the whole packet and pops one flit per grant cycle.
- Returns a credit upstream for every flit popped.

Parameters:
DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] = flit type, bits [NODE_ID_WIDTH-1:0] = destination id (head flit only)
DEPTH, 4, FIFO entries (power of two, >=2)
NODE_ID_WIDTH, 4, hypercube dimension (16 nodes)
PORT_NUM, 5, one-hot port width = NODE_ID_WIDTH+1; bit i = dimension i, bit PORT_NUM-1 = local
VCH_WIDTH_NUM, 2, VC id width
VC_ID, 0, this instance's VC number
MY_ID, 0, this router's node id

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
ivalid  input  1  flit write strobe from upstream link
idata  input  DATA_WIDTH  incoming flit
grant  input  1  this VC's bit of the mux's current-cycle select (vcsel)
ovalid  output  1  registered: odata holds a popped flit this cycle
ovch  output  VCH_WIDTH_NUM  VC_ID while ovalid, else 0
odata  output  DATA_WIDTH  registered popped flit
port  output  PORT_NUM  one-hot route of current packet; 0 when no packet is routed
req  output  1  crossbar request
credit_out  output  1  one-cycle pulse per flit popped
count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky error flag

Behaviour:
- Flit types: 01 head, 00 body, 10 tail, 11 single (head+tail).
- Reset (reset==0, async): FIFO pointers=0, count=0, state=IDLE, ovalid=0, odata=0, ovch=0, port=0, req=0, credit_out=0, overflow=0.
- Push: ivalid && (count<DEPTH || pop this cycle) -> write at wr_ptr, wr_ptr+1 mod DEPTH.
- Overflow: ivalid with count==DEPTH and no pop -> flit dropped, overflow set until reset.
- Pop: pop = grant && req. Reads the FIFO head, rd_ptr+1 mod DEPTH.
  - Simultaneous push+pop leaves count unchanged.
  - Push to an empty FIFO is not visible at the head until the next cycle (no bypass).
- Output register: on a pop cycle N, odata<=head flit, ovalid<=1 at cycle N+1 (1-cycle latency, matches mux selecting data with the registered grant).
  - With no pop, ovalid<=0 and odata holds its last value.
  - credit_out<=pop, same timing as ovalid.
- Route computation (combinational on the head flit): diff = dest ^ MY_ID.
  - diff==0 -> local bit (PORT_NUM-1).
  - Otherwise -> bit of the lowest set bit of diff.
- FSM:
  - IDLE: FIFO non-empty and head type is head or single -> latch port=route, go ROUTE.
  - IDLE, non-head flit at the head: discard it (pop, no ovalid, credit_out pulses) and keep overflow unchanged.
  - ROUTE/ACTIVE: req = (count!=0).
    - Pop of a non-tail flit -> ACTIVE.
    - Pop of a tail or single flit -> port<=0, req drops the next cycle, go IDLE.
  - ACTIVE with an empty FIFO: req=0, port held, state held (bubble).
- port is stable from head latch until the cycle after the tail pop; the mux's port path is combinational on grant, so port must not change while req=1.
- grant without req is ignored (no pop).
- Reset mid-packet: all state cleared immediately; partial packet lost.

Test Plan:
- MY_ID=0: push single flit type 11, dest 4'b0110 -> port=5'b00010, req=1; grant one cycle -> next cycle ovalid=1, odata=flit, ovch=VC_ID, credit_out=1, then req=0, port=0.
- Push head (dest=0) + 2 body + tail, grant held continuously -> port=5'b10000 throughout; 4 consecutive ovalid beats in order; 4 credit pulses; req falls after tail pop.
- Fill DEPTH=4 with no grant, push a 5th flit -> count stays 4, overflow=1 sticky; same-cycle push+pop at full -> accepted, count stays 4, overflow unchanged.
- Head+body popped, FIFO empties before tail -> req=0, port held 5'b00001 (dest 4'b0001); tail arrives -> req=1, pop, IDLE.
- Grant deasserted for 3 cycles mid-packet -> no pops, ovalid=0, odata holds, port stable; resumes in order.
- Assert reset low asynchronously mid-packet (between clock edges) -> all outputs 0 immediately; next head routes correctly.

Source files
------------

// File: rtl/vc_input_buffer.sv
// One virtual-channel input buffer: flit FIFO, e-cube route from the head flit,
// packet-wide crossbar request, registered pop output and upstream credit return.
module vc_input_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int NODE_ID_WIDTH = 4,
  parameter int PORT_NUM      = 5,
  parameter int VCH_WIDTH_NUM = 2,
  parameter int VC_ID         = 0,
  parameter int MY_ID         = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ivalid,
  input  logic [DATA_WIDTH-1:0]    idata,
  input  logic                     grant,
  output logic                     ovalid,
  output logic [VCH_WIDTH_NUM-1:0] ovch,
  output logic [DATA_WIDTH-1:0]    odata,
  output logic [PORT_NUM-1:0]      port,
  output logic                     req,
  output logic                     credit_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_t;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  state_t                   state;

  logic [DATA_WIDTH-1:0]    head_flit;
  logic                     empty;
  logic                     full;
  logic                     head_is_head;
  logic                     head_is_tail;
  logic                     pop_grant;
  logic                     discard;
  logic                     pop;
  logic                     push;
  logic [NODE_ID_WIDTH-1:0] diff;
  logic [PORT_NUM-1:0]      route;

  assign head_flit    = mem[rd_ptr];
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  // Type encoding: bit DW-2 marks a packet start (head/single), bit DW-1 an end (tail/single).
  assign head_is_head = head_flit[DATA_WIDTH-2];
  assign head_is_tail = head_flit[DATA_WIDTH-1];

  assign req       = (state != IDLE) && !empty;
  assign pop_grant = grant && req;
  // Stray body/tail flits reaching the head while idle are dropped, but still return a credit.
  assign discard   = (state == IDLE) && !empty && !head_is_head;
  assign pop       = pop_grant || discard;
  assign push      = ivalid && (!full || pop);

  // E-cube routing: correct the lowest differing dimension first; no difference means local.
  assign diff = head_flit[NODE_ID_WIDTH-1:0] ^ NODE_ID_WIDTH'(MY_ID);

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    route = '0;
    if (diff == '0) begin
      route[PORT_NUM-1] = 1'b1;
    end else begin
      for (int i = NODE_ID_WIDTH - 1; i >= 0; i--) begin
        if (diff[i]) begin
          route    = '0;
          route[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= idata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ivalid && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      port       <= '0;
      ovalid     <= 1'b0;
      odata      <= '0;
      ovch       <= '0;
      credit_out <= 1'b0;
    end else begin
      ovalid     <= pop_grant;
      credit_out <= pop;
      ovch       <= pop_grant ? VCH_WIDTH_NUM'(VC_ID) : '0;
      if (pop_grant) odata <= head_flit;

      // port only changes in IDLE (req low) or on the tail pop, so the mux never sees it move under req.
      case (state)
        IDLE: begin
          if (!empty && head_is_head) begin
            port  <= route;
            state <= ROUTE;
          end
        end
        ROUTE, ACTIVE: begin
          if (pop_grant) begin
            if (head_is_tail) begin
              port  <= '0;
              state <= IDLE;
            end else begin
              state <= ACTIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed scenarios plus random traffic, each cycle compared
// against a queue-based packet model of the buffer.
module tb_vc_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NID   = 4;
  localparam int PN    = 5;
  localparam int VW    = 2;
  localparam int VC    = 2;
  localparam int MY    = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          ivalid;
  logic [DW-1:0] idata;
  logic          grant;
  logic          ovalid;
  logic [VW-1:0] ovch;
  logic [DW-1:0] odata;
  logic [PN-1:0] port;
  logic          req;
  logic          credit_out;
  logic [2:0]    count;
  logic          overflow;

  vc_input_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NODE_ID_WIDTH(NID), .PORT_NUM(PN),
    .VCH_WIDTH_NUM(VW), .VC_ID(VC), .MY_ID(MY)
  ) dut (
    .clk(clk), .reset(reset), .ivalid(ivalid), .idata(idata), .grant(grant),
    .ovalid(ovalid), .ovch(ovch), .odata(odata), .port(port), .req(req),
    .credit_out(credit_out), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int beats = 0;
  int credits = 0;

  // Reference model: packet-level view of the buffer.
  logic [DW-1:0] q[$];
  bit            m_routed;
  logic [PN-1:0] m_port;
  logic          m_ovalid;
  logic [DW-1:0] m_odata;
  logic [VW-1:0] m_ovch;
  logic          m_credit;
  logic          m_overflow;

  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [NID-1:0] dst);
    logic [DW-NID-3:0] pay;
    pay = (DW-NID-2)'($urandom);
    return {t, pay, dst};
  endfunction

  function automatic bit starts_pkt(input logic [DW-1:0] f);
    return (f[DW-1:DW-2] == T_HEAD) || (f[DW-1:DW-2] == T_SINGLE);
  endfunction

  function automatic bit ends_pkt(input logic [DW-1:0] f);
    return (f[DW-1:DW-2] == T_TAIL) || (f[DW-1:DW-2] == T_SINGLE);
  endfunction

  function automatic logic [PN-1:0] route_of(input logic [DW-1:0] f);
    logic [NID-1:0] d;
    d = f[NID-1:0] ^ NID'(MY);
    if (d == '0) return PN'(1) << NID;
    return {1'b0, d & (~d + NID'(1))};
  endfunction

  task automatic model_reset();
    q.delete();
    m_routed = 0; m_port = '0; m_ovalid = 0; m_odata = '0;
    m_ovch = '0; m_credit = 0; m_overflow = 0;
  endtask

  task automatic model_step(input logic iv, input logic [DW-1:0] d, input logic g);
    int            sz;
    logic [DW-1:0] front;
    bit            pg, disc, popped, latch;
    sz     = q.size();
    front  = (sz != 0) ? q[0] : '0;
    pg     = g && m_routed && (sz != 0);
    disc   = !m_routed && (sz != 0) && !starts_pkt(front);
    latch  = !m_routed && (sz != 0) && starts_pkt(front);
    popped = pg || disc;
    if (popped) void'(q.pop_front());
    if (iv) begin
      if (sz < DEPTH || popped) q.push_back(d);
      else m_overflow = 1;
    end
    m_ovalid = pg;
    m_credit = popped;
    m_ovch   = pg ? VW'(VC) : '0;
    if (pg) m_odata = front;
    if (pg && ends_pkt(front)) begin
      m_routed = 0; m_port = '0;
    end else if (latch) begin
      m_routed = 1; m_port = route_of(front);
    end
  endtask

  task automatic compare_all();
    check("ovalid",   32'(ovalid),     32'(m_ovalid));
    check("odata",    odata,           m_odata);
    check("ovch",     32'(ovch),       32'(m_ovch));
    check("port",     32'(port),       32'(m_port));
    check("req",      32'(req),        32'(m_routed && q.size() != 0));
    check("credit",   32'(credit_out), 32'(m_credit));
    check("count",    32'(count),      32'(q.size()));
    check("overflow", 32'(overflow),   32'(m_overflow));
  endtask

  // Drive at the negedge, clock in at the posedge, compare at the following negedge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic g);
    ivalid = iv; idata = d; grant = g;
    @(posedge clk);
    model_step(iv, d, g);
    @(negedge clk);
    compare_all();
    if (ovalid) beats++;
    if (credit_out) credits++;
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    ivalid = 0; grant = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_port", 32'(port), 32'h0);
    check("rst_ovalid", 32'(ovalid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [DW-1:0] f;
  logic [PN-1:0] held;

  initial begin
    reset = 1'b0; ivalid = 0; grant = 0; idata = '0;
    @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b1;

    // Single flit, dest 0110 -> dimension 1.
    f = mk(T_SINGLE, 4'b0110);
    step(1, f, 0);
    check("s_count", 32'(count), 32'd1);
    step(0, '0, 0);
    check("s_port", 32'(port), 32'b00010);
    check("s_req", 32'(req), 32'd1);
    step(0, '0, 1);
    check("s_ovalid", 32'(ovalid), 32'd1);
    check("s_odata", odata, f);
    check("s_ovch", 32'(ovch), 32'(VC));
    check("s_credit", 32'(credit_out), 32'd1);
    check("s_port0", 32'(port), 32'd0);
    check("s_req0", 32'(req), 32'd0);
    step(0, '0, 0);

    // Four-flit packet to the local port with grant held throughout.
    async_reset();
    beats = 0; credits = 0;
    step(1, mk(T_HEAD, 4'b0000), 1);
    step(1, mk(T_BODY, 4'(0)), 1);
    check("p_port", 32'(port), 32'b10000);
    step(1, mk(T_BODY, 4'(0)), 1);
    step(1, mk(T_TAIL, 4'(0)), 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1);
    check("p_beats", 32'(beats), 32'd4);
    check("p_credits", 32'(credits), 32'd4);
    check("p_req_end", 32'(req), 32'd0);

    // Overflow when full, then push+pop at full.
    async_reset();
    step(1, mk(T_HEAD, 4'b0000), 0);
    for (int i = 0; i < 3; i++) step(1, mk(T_BODY, 4'(i)), 0);
    check("o_full", 32'(count), 32'd4);
    check("o_noflag", 32'(overflow), 32'd0);
    step(1, mk(T_BODY, 4'hf), 0);
    check("o_count", 32'(count), 32'd4);
    check("o_flag", 32'(overflow), 32'd1);
    step(1, mk(T_TAIL, 4'h0), 1);
    check("o_pp_count", 32'(count), 32'd4);
    check("o_pp_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) step(0, '0, 1);
    check("o_sticky", 32'(overflow), 32'd1);

    // FIFO empties mid-packet: bubble with port held.
    async_reset();
    step(1, mk(T_HEAD, 4'b0001), 1);
    step(1, mk(T_BODY, 4'h0), 1);
    step(0, '0, 1);
    step(0, '0, 1);
    check("b_req", 32'(req), 32'd0);
    check("b_port", 32'(port), 32'b00001);
    step(0, '0, 1);
    check("b_port2", 32'(port), 32'b00001);
    step(1, mk(T_TAIL, 4'h0), 1);
    check("b_req_tail", 32'(req), 32'd1);
    step(0, '0, 1);
    check("b_tail_ov", 32'(ovalid), 32'd1);
    check("b_port_end", 32'(port), 32'd0);

    // Grant withheld for three cycles mid-packet.
    async_reset();
    step(1, mk(T_HEAD, 4'b0100), 0);
    step(1, mk(T_BODY, 4'h0), 0);
    step(1, mk(T_BODY, 4'h0), 0);
    step(0, '0, 1);
    held = port;
    check("g_port", 32'(held), 32'b00100);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0);
      check("g_stable", 32'(port), 32'(held));
    end
    step(1, mk(T_TAIL, 4'h0), 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Reset in the middle of a packet, then a fresh packet routes correctly.
    async_reset();
    step(1, mk(T_HEAD, 4'b0011), 1);
    step(1, mk(T_BODY, 4'h0), 1);
    step(0, '0, 1);
    async_reset();
    check("r_count", 32'(count), 32'd0);
    step(1, mk(T_SINGLE, 4'b1000), 0);
    step(0, '0, 0);
    check("r_port", 32'(port), 32'b01000);
    step(0, '0, 1);
    step(0, '0, 0);

    // Random traffic: arbitrary flit types, destinations, grants and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      step(($urandom_range(0, 99) < 55),
           mk(2'($urandom_range(0, 3)), 4'($urandom)),
           ($urandom_range(0, 99) < 65));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
